// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a producer/consumer pair and sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 4
);
  logic             flush;
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wdata, winc, rinc,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wdata, winc, rinc,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, flush,
// overflow/underflow pulses and selectable registered or first-word-fall-through read.
module sync_fifo_param #(
  parameter int unsigned DSIZE      = 8,
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AFULL_LVL  = (1 << ASIZE) - 2,
  parameter int unsigned AEMPTY_LVL = 1,
  parameter int unsigned FWFT       = 0
) (
  input logic              i_clk,
  input logic              i_rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned CW    = ASIZE + 1;

  logic [DSIZE-1:0] r_mem [DEPTH];
  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wacc;
  logic w_racc;

  // Status flags decode the registered count only, so they never follow winc/rinc.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wacc  = bus.winc && !w_full  && !bus.flush;
  assign w_racc  = bus.rinc && !w_empty && !bus.flush;

  assign bus.wfull        = w_full;
  assign bus.rempty       = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AFULL_LVL));
  assign bus.almost_empty = (r_count <= CW'(AEMPTY_LVL));
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  // Storage is deliberately left out of reset and flush; pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_wacc) r_mem[r_wptr] <= bus.wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wacc) r_wptr <= r_wptr + ASIZE'(1);
      if (w_racc) r_rptr <= r_rptr + ASIZE'(1);
      r_count     <= r_count + CW'(w_wacc) - CW'(w_racc);
      r_overflow  <= bus.winc && w_full;
      r_underflow <= bus.rinc && w_empty;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DSIZE-1:0] r_rdata;
      // Holds the last popped word, including across flush.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_rdata <= '0;
        else if (w_racc) r_rdata <= r_mem[r_rptr];
      end
      assign bus.rdata = r_rdata;
    end else begin : g_fwft_read
      assign bus.rdata = w_empty ? '0 : r_mem[r_rptr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a registered-read and an FWFT instance share stimulus and are
// checked every cycle against a queue model, plus literal expectations.
module tb_sync_fifo_param;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 2;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_flush = 1'b0;
  logic       s_winc  = 1'b0;
  logic       s_rinc  = 1'b0;
  logic [7:0] s_wdata = 8'h00;
  logic       chk_en  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus0 ();
  sync_fifo_param_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus1 ();

  assign bus0.flush = s_flush;
  assign bus0.winc  = s_winc;
  assign bus0.rinc  = s_rinc;
  assign bus0.wdata = s_wdata;
  assign bus1.flush = s_flush;
  assign bus1.winc  = s_winc;
  assign bus1.rinc  = s_rinc;
  assign bus1.wdata = s_wdata;

  sync_fifo_param #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(0))
    u_reg (.i_clk(clk), .i_rst(rst), .bus(bus0.slave));
  sync_fifo_param #(.DSIZE(DSIZE), .ASIZE(ASIZE), .AFULL_LVL(3), .AEMPTY_LVL(1), .FWFT(1))
    u_fwft (.i_clk(clk), .i_rst(rst), .bus(bus1.slave));

  // Queue model of FIFO contents and the registered side outputs.
  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  logic [7:0] m_rd = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_rd = 8'h00;
    end else if (s_flush) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      automatic int  sz    = q.size();
      automatic bit  full  = (sz == DEPTH);
      automatic bit  empty = (sz == 0);
      m_ov = s_winc && full;
      m_un = s_rinc && empty;
      if (s_rinc && !empty) m_rd = q.pop_front();
      if (s_winc && !full)  q.push_back(s_wdata);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_bus(input string tag, input logic [2:0] cnt, input logic wf, input logic re,
                         input logic af, input logic ae, input logic ov, input logic un,
                         input logic [7:0] rd, input logic [7:0] exp_rd);
    automatic int sz = q.size();
    chk({tag, ".count"},        32'(cnt), 32'(sz));
    chk({tag, ".wfull"},        32'(wf),  32'(sz == DEPTH));
    chk({tag, ".rempty"},       32'(re),  32'(sz == 0));
    chk({tag, ".almost_full"},  32'(af),  32'(sz >= 3));
    chk({tag, ".almost_empty"}, 32'(ae),  32'(sz <= 1));
    chk({tag, ".overflow"},     32'(ov),  32'(m_ov));
    chk({tag, ".underflow"},    32'(un),  32'(m_un));
    chk({tag, ".rdata"},        32'(rd),  32'(exp_rd));
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      cmp_bus("reg", bus0.count, bus0.wfull, bus0.rempty, bus0.almost_full, bus0.almost_empty,
              bus0.overflow, bus0.underflow, bus0.rdata, m_rd);
      cmp_bus("fwft", bus1.count, bus1.wfull, bus1.rempty, bus1.almost_full, bus1.almost_empty,
              bus1.overflow, bus1.underflow, bus1.rdata, (q.size() != 0) ? q[0] : 8'h00);
    end
  end

  task automatic step(input logic w, input logic r, input logic f, input logic [7:0] d);
    s_winc  = w;
    s_rinc  = r;
    s_flush = f;
    s_wdata = d;
    @(posedge clk);
    #1;
    s_winc  = 1'b0;
    s_rinc  = 1'b0;
    s_flush = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Asynchronous reset mid-cycle with words stored
    step(1, 0, 0, 8'hA0);
    step(1, 0, 0, 8'hA1);
    step(1, 0, 0, 8'hA2);
    step(0, 1, 0, 8'h00);
    chk("pre_rst.rdata", 32'(bus0.rdata), 32'hA0);
    chk("pre_rst.fwft_head", 32'(bus1.rdata), 32'hA1);
    #2 rst = 1'b1;
    #1;
    chk("rst.count", 32'(bus0.count), 0);
    chk("rst.rempty", 32'(bus0.rempty), 1);
    chk("rst.almost_empty", 32'(bus0.almost_empty), 1);
    chk("rst.wfull", 32'(bus0.wfull), 0);
    chk("rst.rdata", 32'(bus0.rdata), 0);
    chk("rst.fwft_rdata", 32'(bus1.rdata), 0);
    chk("rst.ovf_unf", 32'({bus0.overflow, bus0.underflow}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill and overflow
    step(1, 0, 0, 8'h10);
    chk("fill1.count", 32'(bus0.count), 1);
    chk("fill1.almost_empty", 32'(bus0.almost_empty), 1);
    chk("fill1.fwft_rdata", 32'(bus1.rdata), 32'h10);
    step(1, 0, 0, 8'h11);
    chk("fill2.almost_empty", 32'(bus0.almost_empty), 0);
    chk("fill2.almost_full", 32'(bus0.almost_full), 0);
    step(1, 0, 0, 8'h12);
    chk("fill3.almost_full", 32'(bus0.almost_full), 1);
    chk("fill3.wfull", 32'(bus0.wfull), 0);
    step(1, 0, 0, 8'h13);
    chk("fill4.wfull", 32'(bus0.wfull), 1);
    chk("fill4.count", 32'(bus0.count), 4);
    step(1, 0, 0, 8'h14);
    chk("ovf.pulse", 32'(bus0.overflow), 1);
    chk("ovf.count", 32'(bus0.count), 4);
    step(0, 0, 0, 8'h00);
    chk("ovf.clear", 32'(bus0.overflow), 0);

    // Drain, underflow
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00);
      chk("drain.rdata", 32'(bus0.rdata), 32'(8'h10 + i));
    end
    chk("drain.rempty", 32'(bus0.rempty), 1);
    step(0, 1, 0, 8'h00);
    chk("unf.pulse", 32'(bus0.underflow), 1);
    chk("unf.rdata_hold", 32'(bus0.rdata), 32'h13);
    step(0, 0, 0, 8'h00);
    chk("unf.clear", 32'(bus0.underflow), 0);

    // Streaming across pointer wrap
    step(1, 0, 0, 8'h20);
    for (int i = 1; i < 6; i++) begin
      step(1, 1, 0, 8'h20 + 8'(i));
      chk("wrap.rdata", 32'(bus0.rdata), 32'(8'h20 + i - 1));
      chk("wrap.count", 32'(bus0.count), 1);
    end
    step(0, 1, 0, 8'h00);
    chk("wrap.last", 32'(bus0.rdata), 32'h25);

    // Simultaneous write and read at full, empty and mid occupancy
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h30 + 8'(i));
    step(1, 1, 0, 8'h34);
    chk("sim_full.overflow", 32'(bus0.overflow), 1);
    chk("sim_full.count", 32'(bus0.count), 3);
    chk("sim_full.rdata", 32'(bus0.rdata), 32'h30);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    chk("sim_full.tail", 32'(bus0.rdata), 32'h33);
    step(1, 1, 0, 8'h40);
    chk("sim_empty.underflow", 32'(bus0.underflow), 1);
    chk("sim_empty.count", 32'(bus0.count), 1);
    chk("sim_empty.rdata_hold", 32'(bus0.rdata), 32'h33);
    step(1, 0, 0, 8'h41);
    step(1, 1, 0, 8'h42);
    chk("sim_mid.count", 32'(bus0.count), 2);
    chk("sim_mid.rdata", 32'(bus0.rdata), 32'h40);
    step(0, 1, 0, 8'h00);
    chk("sim_mid.order1", 32'(bus0.rdata), 32'h41);
    step(0, 1, 0, 8'h00);
    chk("sim_mid.order2", 32'(bus0.rdata), 32'h42);

    // Flush has priority over concurrent write and read
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h50 + 8'(i));
    step(1, 1, 1, 8'h53);
    chk("flush.count", 32'(bus0.count), 0);
    chk("flush.rempty", 32'(bus0.rempty), 1);
    chk("flush.no_err", 32'({bus0.overflow, bus0.underflow}), 0);
    chk("flush.rdata_hold", 32'(bus0.rdata), 32'h42);
    chk("flush.fwft_rdata", 32'(bus1.rdata), 0);
    step(1, 0, 0, 8'hAA);
    step(0, 1, 0, 8'h00);
    chk("flush.after", 32'(bus0.rdata), 32'hAA);

    // FWFT visibility
    step(1, 0, 0, 8'h5A);
    chk("fwft.visible", 32'(bus1.rdata), 32'h5A);
    step(0, 1, 0, 8'h00);
    chk("fwft.popped_empty", 32'(bus1.rempty), 1);
    chk("fwft.popped_zero", 32'(bus1.rdata), 0);
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    chk("fwft.head1", 32'(bus1.rdata), 32'h01);
    step(0, 1, 0, 8'h00);
    chk("fwft.head2", 32'(bus1.rdata), 32'h02);
    step(0, 1, 0, 8'h00);
    chk("fwft.drained", 32'(bus1.rdata), 0);
    chk("fwft.reg_last", 32'(bus0.rdata), 32'h02);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO that buffers DSIZE-bit words between producer and consumer stages in the same clock domain, e.g. instruction queue to issue, or CDB to commit. It generalises the team's dual-clock FIFO with:
- configurable depth;
- an occupancy count and programmable almost-full/almost-empty thresholds;
- a synchronous flush for pipeline squash;
- overflow/underflow error pulses;
- a selectable first-word-fall-through read mode.

## Interface
- DSIZE, 8, data width in bits (≥1)
- ASIZE, 4, address width; depth DEPTH = 2^ASIZE entries (ASIZE ≥1)
- AFULL_LVL, 2^ASIZE-2, almost_full asserts when count ≥ AFULL_LVL (1..DEPTH)
- AEMPTY_LVL, 1, almost_empty asserts when count ≤ AEMPTY_LVL (0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents
- wdata  in  DSIZE  write data
- winc  in  1  write request
- rinc  in  1  read/pop request
- rdata  out  DSIZE  read data
- wfull  out  1  count == DEPTH
- rempty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LVL
- almost_empty  out  1  count ≤ AEMPTY_LVL
- count  out  ASIZE+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected because full
- underflow  out  1  one-cycle pulse: read rejected because empty

## Operation
- Storage: DEPTH×DSIZE register array; write pointer wptr and read pointer rptr, each ASIZE bits, wrapping modulo DEPTH naturally; count register ASIZE+1 bits.
- Write accept: winc && !wfull && !flush. mem[wptr] <= wdata, wptr+1.
- Read accept: rinc && !rempty && !flush. rptr+1.
- Flags are evaluated on the pre-edge registered state. Consequences:
  - Full with winc&rinc: read accepted, write rejected, overflow pulses, count = DEPTH-1.
  - Empty with winc&rinc: write accepted, read rejected, underflow pulses, count = 1.
  - Otherwise, both accepted: count unchanged.
- count next = count + wacc − racc.
- wfull, rempty, almost_full and almost_empty are combinational decodes of the registered count only; no combinational path from winc/rinc.
- overflow <= winc && wfull && !flush; underflow <= rinc && rempty && !flush. Each is registered, high for exactly one cycle per offending request.
- flush: wptr, rptr and count go to 0 next edge. Flush has priority over winc/rinc, suppresses overflow/underflow, and does not clear the memory array.
- FWFT=0: on read accept, rdata <= mem[rptr] at that edge. Otherwise rdata holds its value, including across flush.
- FWFT=1: rdata = rempty ? 0 : mem[rptr] combinationally. The head word is visible whenever !rempty, and rinc pops it.
- rst (async): wptr=rptr=count=0, overflow=underflow=0, registered rdata=0. Hence rempty=1, wfull=0, almost_empty=1, almost_full=0. Reset mid-operation discards all contents immediately; state after deassertion is identical to power-up.

## Timing
- Write-to-visible latency: a word written at edge N sets rempty=0 and increments count after edge N.
  - FWFT=1: the word appears on rdata in cycle N+1.
  - FWFT=0: rinc asserted in cycle N+1 delivers the word on rdata after edge N+1.
- Read latency FWFT=0: 1 clock from the accepting edge. FWFT=1: 0 clocks (data valid before rinc).
- Throughput: one write and one read per cycle sustained; no bubbles at pointer wrap.
- Flag update: all status outputs change only after a clk edge or on rst assertion.
- rst deassertion must be synchronised externally; the block gives no guarantee on the first edge if rst releases near clk.

## Test plan
Configuration unless noted: DSIZE=8, ASIZE=2 (DEPTH=4), AFULL_LVL=3, AEMPTY_LVL=1, FWFT=0.
- Reset: assert rst mid-cycle with 2 words stored → immediately count=0, rempty=1, almost_empty=1, wfull=0, rdata=0, overflow=underflow=0.
- Fill/overflow: write 0x10,0x11,0x12,0x13 on consecutive cycles → count 1,2,3,4; almost_empty drops after the 2nd write; almost_full rises after the 3rd; wfull after the 4th. A 5th write (0x14) → overflow pulses 1 cycle, count stays 4, 0x14 never read.
- Drain/underflow/wrap: after fill, pop 4 times → rdata 0x10..0x13, each 1 cycle after its pop, rempty=1 after the 4th. A 5th pop → underflow pulse, rdata holds 0x13. Then write/read 6 more words → in-order data across pointer wrap.
- Simultaneous: winc&rinc while full → overflow=1, count 4→3. winc&rinc while empty → underflow=1, count 0→1. winc&rinc with count=2 → count stays 2, order preserved.
- Flush: count=3, assert flush together with winc&rinc → next cycle count=0, rempty=1, no overflow/underflow, rdata unchanged. A subsequent write of 0xAA then pop → rdata=0xAA.
- FWFT=1: write 0x5A → rdata=0x5A the next cycle without rinc. Pop → rempty=1, rdata=0. Back-to-back writes 0x01,0x02 then pops → rdata shows 0x01, then 0x02.
